// File: rtl/tt_autosel_mux_stepper.sv
// Drives the TT mux control pins to select a design: a reset pulse on the address counter,
// then one increment pulse per index step, then a settle period before enable.
module tt_autosel_mux_stepper #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RST_CYC    = 8,
  parameter int unsigned HALF_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_valid_i,
  input  logic [ADDR_W-1:0] sel_addr_i,
  output logic              ctrl_sel_rst_n_o,
  output logic              ctrl_sel_inc_o,
  output logic              ctrl_ena_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned MaxCyc0 = (RST_CYC > HALF_CYC) ? RST_CYC : HALF_CYC;
  localparam int unsigned MaxCyc  = (MaxCyc0 > SETTLE_CYC) ? MaxCyc0 : SETTLE_CYC;
  localparam int unsigned TimerW  = $clog2(MaxCyc + 1);

  // Timer reload values hold the remaining cycles after the current one.
  localparam logic [TimerW-1:0] RstLd    = TimerW'(RST_CYC - 1);
  localparam logic [TimerW-1:0] HalfLd   = TimerW'(HALF_CYC - 1);
  localparam logic [TimerW-1:0] SettleLd = TimerW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRstLo,
    StRstGap,
    StIncHi,
    StIncLo,
    StSettle,
    StEnabled
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sel_rst_n_q, sel_rst_n_d;
  logic                sel_inc_q, sel_inc_d;
  logic                ena_q, ena_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_zero;
  logic                cnt_zero;

  assign tmr_zero = (timer_q == '0);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = tmr_zero ? timer_q : timer_q - 1'b1;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StEnabled: begin
        timer_d = '0;
        if (sel_valid_i) begin
          state_d = StRstLo;
          timer_d = RstLd;
          cnt_d   = sel_addr_i;
        end
      end
      StRstLo: begin
        if (tmr_zero) begin
          state_d = StRstGap;
          timer_d = HalfLd;
        end
      end
      StRstGap, StIncLo: begin
        if (tmr_zero) begin
          state_d = cnt_zero ? StSettle : StIncHi;
          timer_d = cnt_zero ? SettleLd : HalfLd;
        end
      end
      StIncHi: begin
        if (tmr_zero) begin
          state_d = StIncLo;
          timer_d = HalfLd;
          cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (tmr_zero) begin
          state_d = StEnabled;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with state_q.
  always_comb begin
    sel_rst_n_d = (state_d != StRstLo);
    sel_inc_d   = (state_d == StIncHi);
    ena_d       = (state_d == StEnabled);
    busy_d      = (state_d != StIdle) && (state_d != StEnabled);
    done_d      = (state_d == StEnabled) && (state_q != StEnabled);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cnt_q       <= '0;
      sel_rst_n_q <= 1'b1;
      sel_inc_q   <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      sel_rst_n_q <= sel_rst_n_d;
      sel_inc_q   <= sel_inc_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ctrl_sel_rst_n_o = sel_rst_n_q;
  assign ctrl_sel_inc_o   = sel_inc_q;
  assign ctrl_ena_o       = ena_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_tt_autosel_mux_stepper.sv
// Directed bench for tt_autosel_mux_stepper: latency, pulse counts and widths, re-select,
// ignored mid-sequence strobes and reset abort, with default parameters.
module tb_tt_autosel_mux_stepper;

  logic       clk;
  logic       rst;
  logic       sel_valid;
  logic [9:0] sel_addr;
  logic       rst_n;
  logic       inc;
  logic       ena;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the negedge monitor.
  int pulses = 0;
  int hi_run = 0;
  int gap_run = 0;
  bit gap_on = 0;
  int lo_run = 0;
  int last_rst_lo = 0;
  int width_err = 0;
  int inv_err = 0;
  bit prev_inc = 0;
  bit chk_width = 1;

  tt_autosel_mux_stepper dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sel_valid_i     (sel_valid),
    .sel_addr_i      (sel_addr),
    .ctrl_sel_rst_n_o(rst_n),
    .ctrl_sel_inc_o  (inc),
    .ctrl_ena_o      (ena),
    .busy_o          (busy),
    .done_o          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc === 1'b1) begin
      if (!prev_inc) pulses++;
      if (gap_on && chk_width && gap_run != 4) width_err++;
      gap_on = 0;
      hi_run++;
    end else begin
      if (hi_run != 0) begin
        if (chk_width && hi_run != 4) width_err++;
        hi_run  = 0;
        gap_on  = 1;
        gap_run = 0;
      end
      if (gap_on) gap_run++;
    end
    if (busy !== 1'b1) gap_on = 0;
    if (rst_n === 1'b0) lo_run++;
    else if (lo_run != 0) begin
      last_rst_lo = lo_run;
      lo_run = 0;
    end
    if (rst_n === 1'b0 && inc === 1'b1) inv_err++;
    if (ena === 1'b1 && busy === 1'b1) inv_err++;
    prev_inc = (inc === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch a selection and follow it to done; optionally inject a stray strobe (addr 3)
  // while the inject_at-th increment pulse is high.
  task automatic run_seq(input string tag, input logic [9:0] addr, input int exp_lat,
                         input int exp_pulses, input int inject_at);
    int k;
    int p0;
    bit injected;
    p0 = pulses;
    injected = 0;
    sel_valid = 1'b1;
    sel_addr  = addr;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
    sel_addr  = '0;
    k = 1;
    check({tag, "_ena_first"}, 32'(ena), 32'd0);
    check({tag, "_busy_first"}, 32'(busy), 32'd1);
    check({tag, "_rstn_first"}, 32'(rst_n), 32'd0);
    while (done !== 1'b1 && k < exp_lat + 50) begin
      if (inject_at >= 0 && !injected && (pulses - p0) == inject_at && inc === 1'b1) begin
        sel_valid = 1'b1;
        sel_addr  = 10'd3;
        injected  = 1;
      end
      @(posedge clk);
      #1;
      sel_valid = 1'b0;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_pulses"}, 32'(pulses - p0), 32'(exp_pulses));
    check({tag, "_ena"}, 32'(ena), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_rst_lo_len"}, 32'(last_rst_lo), 32'd8);
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_ena_hold"}, 32'(ena), 32'd1);
  endtask

  initial begin
    int k;
    int dseen;
    rst       = 1'b1;
    sel_valid = 1'b0;
    sel_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rstn", 32'(rst_n), 32'd1);
    check("reset_inc", 32'(inc), 32'd0);
    check("reset_ena", 32'(ena), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // addr 5: 1 + 8 + 4 + 2*4*5 + 16 = 69
    run_seq("addr5", 10'd5, 69, 5, -1);
    // Re-select from ENABLED: 1 + 8 + 4 + 16 + 16 = 45
    run_seq("resel2", 10'd2, 45, 2, -1);
    // Stray strobe during the second pulse is ignored.
    run_seq("ignore", 10'd5, 69, 5, 2);

    // Reset during INC_HI aborts the sequence.
    sel_valid = 1'b1;
    sel_addr  = 10'd1;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
    k = 0;
    while (inc !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_reach_inc", 32'(inc), 32'd1);
    chk_width = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_inc", 32'(inc), 32'd0);
    check("abort_rstn", 32'(rst_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ena", 32'(ena), 32'd0);
    dseen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dseen++;
    end
    check("abort_stays_idle", 32'(dseen), 32'd0);
    chk_width = 1;

    // addr 0: no increments, 1 + 8 + 4 + 16 = 29
    run_seq("addr0", 10'd0, 29, 0, -1);
    // Max address: 1 + 8 + 4 + 8*1023 + 16 = 8213
    run_seq("addr1023", 10'd1023, 8213, 1023, -1);

    check("pulse_widths", 32'(width_err), 32'd0);
    check("invariants", 32'(inv_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
